// File: rtl/sine_dds_phase_sched_pkg.sv
// Shared types for the DDS phase scheduler: FSM states and config-select encodings.
// No logic, no latency, no flow control.
package sine_dds_phase_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic CFG_SEL_FREQ   = 1'b0;
  localparam logic CFG_SEL_OFFSET = 1'b1;

endpackage

// File: rtl/sine_dds_phase_sched_if.sv
// AXI-stream phase channel from the scheduler to the sine LUT.
// Standard valid/ready: the payload holds while tvalid=1 and tready=0.
interface sine_dds_phase_sched_if #(
  parameter int PHASE_WIDTH = 18,
  parameter int CH_WIDTH    = 2
) ();
  logic [PHASE_WIDTH-1:0] tdata;
  logic [CH_WIDTH-1:0]    tdest;
  logic                   tlast;
  logic                   tvalid;
  logic                   tready;

  modport master (output tdata, output tdest, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tdest, input tlast, input tvalid, output tready);
endinterface

// File: rtl/sine_dds_cfg_bank.sv
// Shadow + active frequency/offset registers; writes land in shadow, apply copies all at once.
// Read port is combinational and forwards shadow on the apply cycle so the beat loaded then sees the new set.
module sine_dds_cfg_bank
  import sine_dds_phase_sched_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int CH_WIDTH  = 2,
  parameter int ACC_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic                 wr_sel,
  input  logic [CH_WIDTH-1:0]  wr_ch,
  input  logic [ACC_WIDTH-1:0] wr_data,
  input  logic                 apply,
  input  logic [CH_WIDTH-1:0]  rd_ch,
  output logic [ACC_WIDTH-1:0] rd_freq,
  output logic [ACC_WIDTH-1:0] rd_off
);

  logic [ACC_WIDTH-1:0] shadow_freq [CHANNELS];
  logic [ACC_WIDTH-1:0] shadow_off  [CHANNELS];
  logic [ACC_WIDTH-1:0] active_freq [CHANNELS];
  logic [ACC_WIDTH-1:0] active_off  [CHANNELS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_freq[i] <= '0;
        shadow_off[i]  <= '0;
        active_freq[i] <= '0;
        active_off[i]  <= '0;
      end
    end else begin
      // Active takes the pre-write shadow when a write and apply coincide.
      if (apply) begin
        for (int i = 0; i < CHANNELS; i++) begin
          active_freq[i] <= shadow_freq[i];
          active_off[i]  <= shadow_off[i];
        end
      end
      if (wr_en) begin
        case (wr_sel)
          CFG_SEL_FREQ:   shadow_freq[wr_ch] <= wr_data;
          CFG_SEL_OFFSET: shadow_off[wr_ch]  <= wr_data;
          default:        ;
        endcase
      end
    end
  end

  assign rd_freq = apply ? shadow_freq[rd_ch] : active_freq[rd_ch];
  assign rd_off  = apply ? shadow_off[rd_ch]  : active_off[rd_ch];

endmodule

// File: rtl/sine_dds_phase_sched.sv
// Round-robin per-channel phase accumulators feeding one LUT; tvalid one cycle after entering RUN, then a beat per cycle.
// Output register reloads on !tvalid|tready; stalls hold the beat; frames always complete before stopping.
module sine_dds_phase_sched
  import sine_dds_phase_sched_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int CH_WIDTH    = 2,
  parameter int ACC_WIDTH   = 32,
  parameter int PHASE_WIDTH = 18
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 cfg_wr_en,
  input  logic                 cfg_wr_sel,
  input  logic [CH_WIDTH-1:0]  cfg_wr_ch,
  input  logic [ACC_WIDTH-1:0] cfg_wr_data,
  input  logic                 cfg_commit,
  input  logic                 cfg_sync,
  output logic                 commit_pending,
  sine_dds_phase_sched_if.master output_phase
);

  state_t                 state, state_nxt;
  logic                   load, stop;
  logic [CH_WIDTH-1:0]    ch;
  logic [ACC_WIDTH-1:0]   acc [CHANNELS];
  logic                   pending, sync_latched;
  logic [PHASE_WIDTH-1:0] tdata_q;
  logic [CH_WIDTH-1:0]    tdest_q;
  logic                   tlast_q, tvalid_q;
  logic                   hs, last_hs, apply, zero_accs;
  logic [ACC_WIDTH-1:0]   rd_freq, rd_off, eff_acc, phase_sum;

  assign hs        = tvalid_q & output_phase.tready;
  assign last_hs   = hs & tlast_q;
  assign apply     = pending & ((state == ST_IDLE) | last_hs);
  assign zero_accs = apply & sync_latched;

  sine_dds_cfg_bank #(
    .CHANNELS (CHANNELS),
    .CH_WIDTH (CH_WIDTH),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_cfg_bank (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (cfg_wr_en),
    .wr_sel (cfg_wr_sel),
    .wr_ch  (cfg_wr_ch),
    .wr_data(cfg_wr_data),
    .apply  (apply),
    .rd_ch  (ch),
    .rd_freq(rd_freq),
    .rd_off (rd_off)
  );

  // A beat loaded on the boundary edge belongs to the new frame, so it sees the synced accumulator.
  assign eff_acc   = zero_accs ? '0 : acc[ch];
  assign phase_sum = eff_acc + rd_off;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    stop      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!enable && (!tvalid_q || last_hs)) begin
          state_nxt = ST_IDLE;
          stop      = 1'b1;
        end else begin
          load = !tvalid_q || output_phase.tready;
          if (!enable) state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (last_hs) begin
          state_nxt = ST_IDLE;
          stop      = 1'b1;
        end else begin
          load = !tvalid_q || output_phase.tready;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      ch           <= '0;
      pending      <= 1'b0;
      sync_latched <= 1'b0;
      tdata_q      <= '0;
      tdest_q      <= '0;
      tlast_q      <= 1'b0;
      tvalid_q     <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
    end else begin
      state <= state_nxt;
      if (zero_accs) begin
        for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
      end
      if (load) begin
        acc[ch]  <= eff_acc + rd_freq;
        ch       <= ch + 1'b1;
        tdata_q  <= PHASE_WIDTH'(phase_sum >> (ACC_WIDTH - PHASE_WIDTH));
        tdest_q  <= ch;
        tlast_q  <= (ch == CH_WIDTH'(CHANNELS - 1));
        tvalid_q <= 1'b1;
      end else if (stop) begin
        tvalid_q <= 1'b0;
      end
      // A new commit on the applying edge re-arms for the following boundary.
      if (cfg_commit) begin
        pending      <= 1'b1;
        sync_latched <= apply ? cfg_sync : (sync_latched | cfg_sync);
      end else if (apply) begin
        pending      <= 1'b0;
        sync_latched <= 1'b0;
      end
    end
  end

  assign commit_pending      = pending;
  assign output_phase.tdata  = tdata_q;
  assign output_phase.tdest  = tdest_q;
  assign output_phase.tlast  = tlast_q;
  assign output_phase.tvalid = tvalid_q;

endmodule
